// File: rtl/wb_ram_dp.sv
// wb_ram_dp: dual-port Wishbone B4 RAM model.
//   i port: read-only, d port: read/write, both over one shared word array.
//   Classic, constant-address and incrementing (linear / wrap4/8/16) bursts.
//   WAIT_STATES idle cycles precede the first ack of every cycle; burst beats
//   after the first are acked back-to-back.
// Build option:
//   WB_RAM_ERR_EN - address mismatch against BASE_ADDR or an illegal cti
//                   answers with err instead of ack and performs no access.
//                   Without it err is tied low, upper address bits alias and
//                   illegal cti behaves as classic.

// One Wishbone slave port controller: FSM, wait counter and beat address.
// The read data register lives in the top so both ports share one array.
module wb_ram_dp_port #(
    parameter int          ADDR_WIDTH  = 20,
    parameter int          LSB         = 2,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           addr,
    input  logic                  cyc,
    input  logic                  stb,
    input  logic [2:0]            cti,
    input  logic [1:0]            bte,
    output logic                  ack,
    output logic                  err,
    output logic                  ld,
    output logic [ADDR_WIDTH-1:0] ld_addr,
    output logic [ADDR_WIDTH-1:0] beat_addr
);
    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

    localparam logic [3:0]            WS_LOAD = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
    localparam logic [ADDR_WIDTH-1:0] ONE     = 1;

    state_t                state, state_nxt;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] cur, adv, req;
    logic                  beat, fault, cont;

    assign req       = addr[ADDR_WIDTH+LSB-1:LSB];
    assign beat      = (state == BURST) && cyc && stb;
    // only 001/010 keep the cycle going; everything else ends it after this beat
    assign cont      = beat && !fault && (cti == 3'b001 || cti == 3'b010);
    assign ack       = beat && !fault;
    assign err       = beat && fault;
    assign beat_addr = cur;

`ifdef WB_RAM_ERR_EN
    localparam logic [31:0] HI_MASK = 32'(~((64'd1 << (ADDR_WIDTH + LSB)) - 64'd1));
    logic bad;
    logic illegal;

    assign illegal = cti inside {[3'd3:3'd6]};
    assign fault   = bad || illegal;

    // upper address bits are checked once, at request time
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bad <= 1'b0;
        else if (state == IDLE && cyc && stb)
            bad <= ((addr ^ BASE_ADDR) & HI_MASK) != 32'h0;
    end

    // simulation notice for an illegal cycle type on an answered beat
    always_ff @(posedge clk) begin
        if (beat && illegal)
            $display("wb_ram_dp: illegal cti %b at word %h", cti, cur);
    end

    logic unused_addr;
    assign unused_addr = ^addr[LSB-1:0];
`else
    assign fault = 1'b0;

    logic unused_addr;
    assign unused_addr = ^{addr[LSB-1:0], addr[31:ADDR_WIDTH+LSB], BASE_ADDR};
`endif

    // next beat address: linear or wrap within 4/8/16 words; 001 holds
    always_comb begin
        adv = cur;
        if (cti == 3'b010) begin
            case (bte)
                2'b00:   adv      = cur + ONE;
                2'b01:   adv[1:0] = cur[1:0] + 2'd1;
                2'b10:   adv[2:0] = cur[2:0] + 3'd1;
                default: adv[3:0] = cur[3:0] + 4'd1;
            endcase
        end
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next state and read-data load strobe
    always_comb begin
        state_nxt = state;
        ld        = 1'b0;
        ld_addr   = cur;
        case (state)
            IDLE: begin
                if (cyc && stb) begin
                    if (WAIT_STATES == 0) begin
                        state_nxt = BURST;
                        ld        = 1'b1;
                        ld_addr   = req;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!cyc) begin
                    state_nxt = IDLE;
                end else if (cnt == 4'd0) begin
                    state_nxt = BURST;
                    ld        = 1'b1;
                end
            end
            BURST: begin
                if (!cyc) begin
                    state_nxt = IDLE;
                end else if (stb) begin
                    if (cont) begin
                        ld      = 1'b1;
                        ld_addr = adv;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // wait counter and beat address register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 4'd0;
            cur <= '0;
        end else begin
            case (state)
                IDLE:    if (cyc && stb) begin
                             cur <= req;
                             cnt <= WS_LOAD;
                         end
                WAIT:    cnt <= cnt - 4'd1;
                BURST:   if (cont) cur <= adv;
                default: ;
            endcase
        end
    end
endmodule

module wb_ram_dp #(
    parameter int          ADDR_WIDTH  = 20,
    parameter int          DATA_WIDTH  = 32,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             iwbs_addr,
    input  logic                    iwbs_cyc,
    input  logic                    iwbs_stb,
    input  logic [2:0]              iwbs_cti,
    input  logic [1:0]              iwbs_bte,
    output logic [DATA_WIDTH-1:0]   iwbs_dat_r,
    output logic                    iwbs_ack,
    output logic                    iwbs_err,
    input  logic [31:0]             dwbs_addr,
    input  logic [DATA_WIDTH-1:0]   dwbs_dat_w,
    input  logic [DATA_WIDTH/8-1:0] dwbs_sel,
    input  logic                    dwbs_cyc,
    input  logic                    dwbs_stb,
    input  logic                    dwbs_we,
    input  logic [2:0]              dwbs_cti,
    input  logic [1:0]              dwbs_bte,
    output logic [DATA_WIDTH-1:0]   dwbs_dat_r,
    output logic                    dwbs_ack,
    output logic                    dwbs_err
);
    localparam int SW    = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(SW);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  i_ld, d_ld;
    logic [ADDR_WIDTH-1:0] i_ld_addr, d_ld_addr, d_cur, unused_i_cur;
    logic [DATA_WIDTH-1:0] i_dat, d_dat;

    wb_ram_dp_port #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LSB        (LSB),
        .WAIT_STATES(WAIT_STATES),
        .BASE_ADDR  (BASE_ADDR)
    ) u_iport (
        .clk      (clk),
        .rst      (rst),
        .addr     (iwbs_addr),
        .cyc      (iwbs_cyc),
        .stb      (iwbs_stb),
        .cti      (iwbs_cti),
        .bte      (iwbs_bte),
        .ack      (iwbs_ack),
        .err      (iwbs_err),
        .ld       (i_ld),
        .ld_addr  (i_ld_addr),
        .beat_addr(unused_i_cur)
    );

    wb_ram_dp_port #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LSB        (LSB),
        .WAIT_STATES(WAIT_STATES),
        .BASE_ADDR  (BASE_ADDR)
    ) u_dport (
        .clk      (clk),
        .rst      (rst),
        .addr     (dwbs_addr),
        .cyc      (dwbs_cyc),
        .stb      (dwbs_stb),
        .cti      (dwbs_cti),
        .bte      (dwbs_bte),
        .ack      (dwbs_ack),
        .err      (dwbs_err),
        .ld       (d_ld),
        .ld_addr  (d_ld_addr),
        .beat_addr(d_cur)
    );

    // read data is fetched the edge before its ack beat, so a d write
    // committing on that same edge is not visible (read-before-write)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_dat <= '0;
            d_dat <= '0;
        end else begin
            if (i_ld) i_dat <= mem[i_ld_addr];
            if (d_ld) d_dat <= mem[d_ld_addr];
        end
    end

    // byte-masked write at the end of each acked d write beat; no reset
    always_ff @(posedge clk) begin
        if (dwbs_ack && dwbs_we) begin
            for (int b = 0; b < SW; b++)
                if (dwbs_sel[b]) mem[d_cur][8*b +: 8] <= dwbs_dat_w[8*b +: 8];
        end
    end

    assign iwbs_dat_r = iwbs_ack ? i_dat : '0;
    assign dwbs_dat_r = dwbs_ack ? d_dat : '0;
endmodule

// File: tb/tb_wb_ram_dp.sv
// Randomized self-checking bench for wb_ram_dp (WAIT_STATES=3, 1 Ki words).
// Reference model: a plain word array updated on every acked write beat;
// burst beat addresses and ack timing are computed arithmetically.
// Build with WB_RAM_ERR_EN defined to exercise the err response.
module tb_wb_ram_dp;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int WS = 3;
`ifdef WB_RAM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk, rst;
    logic [31:0]   iwbs_addr;
    logic          iwbs_cyc, iwbs_stb;
    logic [2:0]    iwbs_cti;
    logic [1:0]    iwbs_bte;
    logic [DW-1:0] iwbs_dat_r;
    logic          iwbs_ack, iwbs_err;
    logic [31:0]   dwbs_addr;
    logic [DW-1:0] dwbs_dat_w;
    logic [3:0]    dwbs_sel;
    logic          dwbs_cyc, dwbs_stb, dwbs_we;
    logic [2:0]    dwbs_cti;
    logic [1:0]    dwbs_bte;
    logic [DW-1:0] dwbs_dat_r;
    logic          dwbs_ack, dwbs_err;

    wb_ram_dp #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BASE_ADDR  (32'h0000_0000),
        .WAIT_STATES(WS)
    ) dut (
        .clk(clk), .rst(rst),
        .iwbs_addr(iwbs_addr), .iwbs_cyc(iwbs_cyc), .iwbs_stb(iwbs_stb),
        .iwbs_cti(iwbs_cti), .iwbs_bte(iwbs_bte), .iwbs_dat_r(iwbs_dat_r),
        .iwbs_ack(iwbs_ack), .iwbs_err(iwbs_err),
        .dwbs_addr(dwbs_addr), .dwbs_dat_w(dwbs_dat_w), .dwbs_sel(dwbs_sel),
        .dwbs_cyc(dwbs_cyc), .dwbs_stb(dwbs_stb), .dwbs_we(dwbs_we),
        .dwbs_cti(dwbs_cti), .dwbs_bte(dwbs_bte), .dwbs_dat_r(dwbs_dat_r),
        .dwbs_ack(dwbs_ack), .dwbs_err(dwbs_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mdl [1024];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) & 32'h3FF);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // byte address of beat i of a burst starting at start
    function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [1:0] bte,
                                              input logic [2:0] cti_mid, input int i);
        int w, len, nw;
        w = word_of(start);
        if (cti_mid != 3'b010) return start;
        len = (bte == 2'd0) ? 0 : (bte == 2'd1) ? 4 : (bte == 2'd2) ? 8 : 16;
        nw = (len == 0) ? (w + i) % 1024 : (w / len) * len + (w + i) % len;
        return 32'(nw * 4);
    endfunction

    task automatic drive(input bit pd, input logic c, input logic s, input logic we,
                         input logic [31:0] a, input logic [2:0] cti, input logic [1:0] bte,
                         input logic [31:0] wd, input logic [3:0] sel);
        if (pd) begin
            dwbs_cyc = c; dwbs_stb = s; dwbs_we = we; dwbs_addr = a;
            dwbs_cti = cti; dwbs_bte = bte; dwbs_dat_w = wd; dwbs_sel = sel;
        end else begin
            iwbs_cyc = c; iwbs_stb = s; iwbs_addr = a; iwbs_cti = cti; iwbs_bte = bte;
        end
    endtask

    // One complete Wishbone cycle of n beats on the d (pd=1) or i port.
    // Starts and ends 1 time unit after a rising edge.
    task automatic xfer(input bit pd, input bit we, input logic [31:0] start,
                        input logic [1:0] bte, input int n, input logic [2:0] cti_mid,
                        input logic [2:0] cti_last, input logic [3:0] sel, input int stall_at,
                        input bit do_chk, input logic [31:0] wd0, output logic [31:0] rd);
        int beat, cyc_n, stall_left, first_lat, w, stalls;
        bit acked, stalled;
        logic ack_s, err_s;
        logic [31:0] dat_s, wd;
        beat = 0; cyc_n = 0; stall_left = 0; first_lat = -1; rd = '0; wd = wd0;
        stalls = (stall_at >= 1 && stall_at < n) ? 2 : 0;
        drive(pd, 1'b1, 1'b1, we, start, (n == 1) ? cti_last : cti_mid, bte, wd, sel);
        while (beat < n && cyc_n < 100) begin
            @(negedge clk);
            ack_s   = pd ? dwbs_ack : iwbs_ack;
            err_s   = pd ? dwbs_err : iwbs_err;
            dat_s   = pd ? dwbs_dat_r : iwbs_dat_r;
            stalled = pd ? !dwbs_stb : !iwbs_stb;
            acked   = 1'b0;
            if (stalled) begin
                chk("stall_no_ack", ack_s, 1'b0);
            end else if (ack_s) begin
                w = word_of(beat_addr(start, bte, cti_mid, beat));
                if (first_lat < 0) begin
                    first_lat = cyc_n;
                    if (do_chk) chk("first_ack_latency", cyc_n, WS + 1);
                end
                if (we) mdl[w] = merge(mdl[w], wd, sel);
                else begin
                    rd = dat_s;
                    if (do_chk) chk(pd ? "d_rdata" : "i_rdata", dat_s, mdl[w]);
                end
                chk("err_low_on_ack", err_s, 1'b0);
                beat++;
                acked = 1'b1;
            end
            @(posedge clk); #1;
            cyc_n++;
            if (beat == n) begin
                drive(pd, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 2'b00, 32'h0, 4'h0);
            end else begin
                if (acked && beat == stall_at) stall_left = 2;
                if (acked) wd = $urandom;
                drive(pd, 1'b1, stall_left == 0, we, beat_addr(start, bte, cti_mid, beat),
                      (beat == n - 1) ? cti_last : cti_mid, bte, wd, sel);
                if (stall_left > 0) stall_left--;
            end
        end
        if (beat != n) chk("xfer_timeout_beats", beat, n);
        else if (do_chk && n > 1) chk("burst_total_cycles", cyc_n, WS + n + stalls + 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, rd5, a;
        int lat, w, op, n, sa;
        logic [1:0] bte;
        logic [2:0] cm, cl;

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 3'b0, 2'b0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 3'b0, 2'b0, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_i_ack", iwbs_ack, 1'b0);
        chk("rst_d_ack", dwbs_ack, 1'b0);
        chk("rst_i_err", iwbs_err, 1'b0);
        chk("rst_d_err", dwbs_err, 1'b0);
        chk("rst_i_dat", iwbs_dat_r, 32'h0);
        chk("rst_d_dat", dwbs_dat_r, 32'h0);
        rst = 1'b0;

        // 1: classic write then classic read, no double ack
        xfer(1, 1, 32'h100, 2'b00, 1, 3'b000, 3'b000, 4'hF, 0, 1, 32'hDEADBEEF, rd);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 3'b000, 2'b00, 32'h0, 4'h0);
        lat = 0;
        forever begin
            @(negedge clk);
            if (iwbs_ack || lat >= 40) break;
            @(posedge clk); #1;
            lat++;
        end
        chk("t1_i_latency", lat, WS + 1);
        chk("t1_i_data", iwbs_dat_r, 32'hDEADBEEF);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_no_double_ack", iwbs_ack, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 3'b0, 2'b0, 32'h0, 4'h0);
        @(posedge clk); #1;

        // 2: partial byte write
        xfer(1, 1, 32'h104, 2'b00, 1, 3'b000, 3'b111, 4'hF, 0, 1, 32'h11223344, rd);
        xfer(1, 1, 32'h104, 2'b00, 1, 3'b000, 3'b000, 4'b0010, 0, 1, 32'h0000AB00, rd);
        xfer(0, 0, 32'h104, 2'b00, 1, 3'b000, 3'b000, 4'h0, 0, 1, 32'h0, rd);
        chk("t2_byte_merge", rd, 32'h1122AB44);
        xfer(1, 1, 32'h104, 2'b00, 1, 3'b000, 3'b000, 4'b0000, 0, 1, 32'hFFFFFFFF, rd);
        xfer(1, 0, 32'h104, 2'b00, 1, 3'b000, 3'b000, 4'h0, 0, 1, 32'h0, rd);
        chk("t2_sel0_noop", rd, 32'h1122AB44);

        // 3: wrap4 burst on i from 0x108
        xfer(1, 1, 32'h108, 2'b00, 2, 3'b010, 3'b111, 4'hF, 0, 1, 32'hA5A50108, rd);
        xfer(0, 0, 32'h108, 2'b01, 4, 3'b010, 3'b111, 4'h0, 0, 1, 32'h0, rd);
        chk("t3_last_wrap_word", rd, 32'h1122AB44);
        xfer(0, 0, 32'h104, 2'b00, 3, 3'b001, 3'b111, 4'h0, 0, 1, 32'h0, rd);

        // 4: stalled d burst write, read back on both ports
        xfer(1, 1, 32'h140, 2'b00, 8, 3'b010, 3'b111, 4'hF, 3, 1, $urandom, rd);
        xfer(0, 0, 32'h140, 2'b00, 8, 3'b010, 3'b111, 4'h0, 0, 1, 32'h0, rd);
        xfer(1, 0, 32'h140, 2'b10, 8, 3'b010, 3'b111, 4'h0, 5, 1, 32'h0, rd);

        // 5: same-cycle d write and i read of one word
        xfer(1, 1, 32'h200, 2'b00, 1, 3'b000, 3'b000, 4'hF, 0, 1, 32'h33, rd);
        fork
            xfer(1, 1, 32'h200, 2'b00, 1, 3'b000, 3'b000, 4'hF, 0, 1, 32'h55, rd);
            xfer(0, 0, 32'h200, 2'b00, 1, 3'b000, 3'b000, 4'h0, 0, 0, 32'h0, rd5);
        join
        chk("t5_read_before_write", rd5, 32'h33);
        xfer(0, 0, 32'h200, 2'b00, 1, 3'b000, 3'b000, 4'h0, 0, 1, 32'h0, rd);
        chk("t5_new_data", rd, 32'h55);

        // 6: async reset with d mid-burst and i in WAIT
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 3'b010, 2'b00, 32'h0, 4'h0);
        repeat (2) begin @(posedge clk); #1; end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h104, 3'b000, 2'b00, 32'h0, 4'h0);
        repeat (4) @(negedge clk);
        chk("t6_d_second_beat_ack", dwbs_ack, 1'b1);
        chk("t6_i_waiting", iwbs_ack, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("t6_d_ack_async_drop", dwbs_ack, 1'b0);
        chk("t6_d_dat_zero", dwbs_dat_r, 32'h0);
        chk("t6_i_ack_low", iwbs_ack, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 3'b0, 2'b0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 3'b0, 2'b0, 32'h0, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        xfer(0, 0, 32'h100, 2'b00, 1, 3'b000, 3'b000, 4'h0, 0, 1, 32'h0, rd);
        chk("t6_mem_kept", rd, 32'hDEADBEEF);
        xfer(1, 0, 32'h104, 2'b00, 1, 3'b000, 3'b000, 4'h0, 0, 1, 32'h0, rd);

        if (ERR_EN) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h8000_0000, 3'b000, 2'b00, 32'h0, 4'h0);
            lat = 0;
            forever begin
                @(negedge clk);
                if (iwbs_ack || iwbs_err || lat >= 40) break;
                @(posedge clk); #1;
                lat++;
            end
            chk("err_latency", lat, WS + 1);
            chk("err_asserted", iwbs_err, 1'b1);
            chk("err_no_ack", iwbs_ack, 1'b0);
            @(posedge clk); #1;
            drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 3'b0, 2'b0, 32'h0, 4'h0);
            @(posedge clk); #1;
        end

        // randomized traffic over words 0xC0..0xFF, prefilled first
        for (int k = 0; k < 4; k++)
            xfer(1, 1, 32'h300 + 32'(k * 64), 2'b00, 16, 3'b010, 3'b111, 4'hF, 0, 1, $urandom, rd);
        for (int k = 0; k < 40; k++) begin
            op = $urandom_range(0, 4);
            w  = $urandom_range(192, 255);
            a  = 32'(w * 4) | 32'($urandom_range(0, 3));
            if (!ERR_EN && $urandom_range(0, 1) == 1) a = a | ($urandom & 32'hFFFF_F000);
            cl = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'b000;
            if (!ERR_EN && $urandom_range(0, 3) == 0) cl = 3'($urandom_range(3, 6));
            case (op)
                0: xfer(1, 1, a, 2'b00, 1, 3'b000, cl, 4'($urandom_range(0, 15)), 0, 1, $urandom, rd);
                1: xfer(0, 0, a, 2'b00, 1, 3'b000, cl, 4'h0, 0, 1, 32'h0, rd);
                2: xfer(1, 0, a, 2'b00, 1, 3'b000, cl, 4'h0, 0, 1, 32'h0, rd);
                default: begin
                    bte = 2'($urandom_range(0, 3));
                    n   = $urandom_range(2, 8);
                    cm  = ($urandom_range(0, 3) == 0) ? 3'b001 : 3'b010;
                    if (bte == 2'b00 && cm == 3'b010 && w > 256 - n) w = 256 - n;
                    sa  = $urandom_range(1, n);
                    xfer(op == 4, op == 4, 32'(w * 4), bte, n, cm, 3'b111, 4'hF, sa, 1, $urandom, rd);
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
